pingpong_buffer_param: RTL and testbench
========================================

// Module: pingpong_buffer_param
// PURPOSE
//  Parametrised double (ping-pong) buffer between a sample writer (mic capture) and a block reader (beamformer/FFT).
//  Writer fills one bank while reader drains the other; banks swap when both sides have signalled completion.
//  Completion is latched from single-cycle pulses. Adds write back-pressure, a read-valid qualifier and a frame counter.
// PARAMETERS
//  DATA_W   32   width of one word
//  DEPTH    256  words per bank; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)  derived localparam, not overridable
//  CNT_W    16   width of frame_cnt and overrun_cnt
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst_n        in   1        asynchronous active-low reset
//  wr_en        in   1        write strobe
//  wr_addr      in   ADDR_W   write address in current write bank
//  wr_data      in   DATA_W   write data
//  wr_done      in   1        one-cycle pulse: write bank complete
//  wr_ready     out  1        write accepted this cycle when high
//  rd_addr      in   ADDR_W   read address in current read bank
//  rd_done      in   1        one-cycle pulse: read bank consumed
//  rd_data      out  DATA_W   read data, 1-cycle latency
//  rd_valid     out  1        read bank holds a completed frame
//  swap         out  1        one-cycle pulse on bank exchange
//  wr_bank      out  1        bank index currently written (0=A,1=B)
//  frame_cnt    out  CNT_W    number of swaps since reset, wraps
// BEHAVIOUR
//  Reset (async, rst_n low): state=RUN, wr_bank=0, wr_flag=rd_flag=0, swap=0, rd_valid=0, frame_cnt=0, rd_data=0, wr_ready=1.
//  Flags: wr_flag set on wr_done, rd_flag set on rd_done; sticky until SWAP. Pulses while flag already set are ignored.
//  rd_flag treated as set while rd_valid=0 (no frame to drain before first swap).
//  FSM RUN: when wr_flag & (rd_flag|~rd_valid) at clock edge -> SWAP. Done pulse in same cycle as check counts (flag OR pulse).
//  FSM SWAP (1 cycle): swap=1, wr_bank toggles, flags cleared, rd_valid<=1, frame_cnt+=1 (mod 2^CNT_W) -> RUN.
//  wr_ready = (state==RUN) & ~wr_flag. Write to bank wr_bank happens iff wr_en & wr_ready; otherwise dropped, RAM unchanged.
//  Write on the cycle wr_done pulses is accepted (flag takes effect next cycle).
//  Read: rd_addr sampled on bank ~wr_bank; rd_data valid next cycle; output mux uses registered bank select,
//   so a read issued in cycle before swap returns the old read bank's data.
//  Read and write never target the same bank; no collision handling needed.
//  RAM contents not reset; rd_data from unwritten words undefined but rd_valid=0 until first swap.
//  Reset mid-frame: all control state returns to reset values immediately; partially written frame discarded.
//  frame_cnt wraps from 2^CNT_W-1 to 0 without flag.
// CONFIGURATION
//  PINGPONG_OVERRUN_EN defined: adds ports overrun (out,1, sticky) and overrun_cnt (out,CNT_W).
//   Each cycle with wr_en & ~wr_ready: overrun_cnt += 1 (saturates at max), overrun<=1. Both cleared only by rst_n.
//  Not defined: ports absent; dropped writes are silent; no extra logic.
// TESTING
//  1 Reset release, write addr 0..DEPTH-1 with data=addr, pulse wr_done -> swap next cycle+1, rd_valid=1, frame_cnt=1, wr_bank=1.
//  2 After 1, read addr 5 -> rd_data=5 one cycle later; write addr 5=0xDEAD to bank B -> read still 5.
//  3 wr_done at t, rd_done at t+10 -> wr_ready=0 t+1..t+11, swap at t+11, wr_bank toggles, wr_ready=1 at t+12.
//  4 wr_done and rd_done same cycle -> exactly one swap pulse, both flags clear; repeat 2^CNT_W swaps -> frame_cnt returns 0.
//  5 rst_n low mid-frame (wr_flag=1) -> wr_bank=0, rd_valid=0, frame_cnt=0 asynchronously; next wr_done -> swap with no rd_done.
//  6 PINGPONG_OVERRUN_EN: 3 writes with wr_ready=0 -> overrun=1, overrun_cnt=3, RAM unchanged; without macro no such ports.

Source files
------------

// File: rtl/pingpong_buffer_param.sv
// rtl/pingpong_buffer_param.sv - parametrised ping-pong sample buffer with back-pressure and frame counter
// Optional feature macro: PINGPONG_OVERRUN_EN (adds overrun / overrun_cnt ports)
module pingpong_buffer_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              swap,
    output logic              wr_bank,
`ifdef PINGPONG_OVERRUN_EN
    output logic              overrun,
    output logic [CNT_W-1:0]  overrun_cnt,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic {ST_RUN, ST_SWAP} state_t;

    state_t state, state_nxt;
    logic   wr_flag, rd_flag;
    logic   wr_accept;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] q_a, q_b;
    logic              rd_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // A done pulse arriving in the checking cycle counts as if its flag were already set.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            ST_RUN: begin
                wr_ready = ~wr_flag;
                if ((wr_flag | wr_done) & (rd_flag | rd_done | ~rd_valid))
                    state_nxt = ST_SWAP;
            end
            ST_SWAP: begin
                swap      = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_flag   <= 1'b0;
            rd_flag   <= 1'b0;
            rd_valid  <= 1'b0;
            frame_cnt <= '0;
        end else if (swap) begin
            wr_bank   <= ~wr_bank;
            wr_flag   <= 1'b0;
            rd_flag   <= 1'b0;
            rd_valid  <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
        end else begin
            if (wr_done) wr_flag <= 1'b1;
            if (rd_done) rd_flag <= 1'b1;
        end
    end

    assign wr_accept = wr_en & wr_ready;

    always_ff @(posedge clk) begin
        if (wr_accept && !wr_bank) mem_a[wr_addr] <= wr_data;
        if (wr_accept &&  wr_bank) mem_b[wr_addr] <= wr_data;
    end

    // Bank select is registered with the data so a read issued just before a swap
    // still returns the bank that was being read when the address was sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a    <= '0;
            q_b    <= '0;
            rd_sel <= 1'b0;
        end else begin
            q_a    <= mem_a[rd_addr];
            q_b    <= mem_b[rd_addr];
            rd_sel <= ~wr_bank;
        end
    end

    assign rd_data = rd_sel ? q_b : q_a;

`ifdef PINGPONG_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (wr_en && !wr_ready) begin
            overrun <= 1'b1;
            if (overrun_cnt != {CNT_W{1'b1}})
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_buffer_param.sv
// tb/tb_pingpong_buffer_param.sv - self-checking bench for pingpong_buffer_param
module tb_pingpong_buffer_param;

    localparam int DW  = 16;
    localparam int DEP = 16;
    localparam int CW  = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_done = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_done = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          swap;
    logic          wr_bank;
    logic [CW-1:0] frame_cnt;
`ifdef PINGPONG_OVERRUN_EN
    logic          overrun;
    logic [CW-1:0] overrun_cnt;
`endif

    pingpong_buffer_param #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data), .rd_valid(rd_valid),
        .swap(swap), .wr_bank(wr_bank),
`ifdef PINGPONG_OVERRUN_EN
        .overrun(overrun), .overrun_cnt(overrun_cnt),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: two banks of words, plus the protocol state in plain terms.
    logic [DW-1:0] m_mem   [2][DEP];
    bit            m_known [2][DEP];
    bit            m_wb, m_wf, m_rf, m_rv, m_swap, m_ov;
    int            m_cnt, m_ovc;
    logic [DW-1:0] m_rd_exp;
    bit            m_rd_known;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wb = 0; m_wf = 0; m_rf = 0; m_rv = 0; m_swap = 0;
        m_cnt = 0; m_ov = 0; m_ovc = 0;
        m_rd_exp = '0; m_rd_known = 1;
    endtask

    task automatic check_outputs();
        bit exp_ready;
        exp_ready = !m_swap && !m_wf;
        chk("wr_ready", wr_ready, exp_ready);
        chk("swap", swap, m_swap);
        chk("wr_bank", wr_bank, m_wb);
        chk("rd_valid", rd_valid, m_rv);
        chk("frame_cnt", frame_cnt, m_cnt);
        if (m_rd_known) chk("rd_data", rd_data, m_rd_exp);
`ifdef PINGPONG_OVERRUN_EN
        chk("overrun", overrun, m_ov);
        chk("overrun_cnt", overrun_cnt, m_ovc);
`endif
    endtask

    // Check outputs, advance the model over one clock edge, then the DUT.
    task automatic cycle();
        bit exp_ready;
        check_outputs();
        exp_ready = !m_swap && !m_wf;
        m_rd_exp   = m_mem[!m_wb][rd_addr];
        m_rd_known = m_known[!m_wb][rd_addr];
        if (wr_en && !exp_ready) begin
            m_ov = 1;
            if (m_ovc < (1 << CW) - 1) m_ovc++;
        end
        if (m_swap) begin
            m_wb = !m_wb; m_wf = 0; m_rf = 0; m_rv = 1;
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_swap = 0;
        end else begin
            if (wr_en && exp_ready) begin
                m_mem[m_wb][wr_addr]   = wr_data;
                m_known[m_wb][wr_addr] = 1;
            end
            if ((m_wf || wr_done) && (m_rf || rd_done || !m_rv)) m_swap = 1;
            if (wr_done) m_wf = 1;
            if (rd_done) m_rf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_done = 0; rd_done = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        chk("rst_wr_bank", wr_bank, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_frame_cnt", frame_cnt, '0);
        chk("rst_swap", swap, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_data", rd_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic both_done_swap();
        wr_done = 1; rd_done = 1;
        cycle();
        wr_done = 0; rd_done = 0;
        cycle();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEP; a++) begin
                m_mem[b][a] = '0;
                m_known[b][a] = 0;
            end
        model_reset();
        #12;
        do_reset();

        // Fill bank A with data = addr, finish with wr_done on the last write.
        for (int i = 0; i < DEP; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i);
            wr_done = (i == DEP - 1);
            cycle();
        end
        idle_inputs();
        chk("t1_swap", swap, 1'b1);
        cycle();
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_wr_bank", wr_bank, 1'b1);

        // Reading bank A is unaffected by writing bank B at the same address.
        rd_addr = 5;
        cycle();
        chk("t2_rd5", rd_data, 16'd5);
        wr_en = 1; wr_addr = 5; wr_data = 16'hDEAD;
        cycle();
        wr_en = 0;
        cycle();
        chk("t2_rd5_after_b_write", rd_data, 16'd5);

        // wr_done at t, rd_done at t+10: swap at t+11.
        wr_done = 1;
        cycle();
        wr_done = 0;
        for (int i = 1; i <= 10; i++) begin
            chk("t3_ready_low", wr_ready, 1'b0);
            rd_done = (i == 10);
            cycle();
        end
        rd_done = 0;
        chk("t3_swap", swap, 1'b1);
        chk("t3_ready_swap", wr_ready, 1'b0);
        cycle();
        chk("t3_ready_high", wr_ready, 1'b1);
        chk("t3_wr_bank", wr_bank, 1'b0);

        // Simultaneous done pulses give one swap; run the counter around its wrap.
        wr_done = 1; rd_done = 1;
        cycle();
        wr_done = 0; rd_done = 0;
        chk("t4_swap", swap, 1'b1);
        cycle();
        chk("t4_one_swap", swap, 1'b0);
        chk("t4_flags_clear", wr_ready, 1'b1);
        while (m_cnt != 0) both_done_swap();
        chk("t4_wrap", frame_cnt, '0);

        // Reset mid-frame with wr_flag set and wr_bank = 1.
        both_done_swap();
        wr_done = 1;
        cycle();
        wr_done = 0;
        cycle();
        chk("t5_pre_bank", wr_bank, 1'b1);
        do_reset();
        wr_done = 1;
        cycle();
        wr_done = 0;
        chk("t5_swap_no_rd_done", swap, 1'b1);
        cycle();

        // Three dropped writes while wr_flag holds wr_ready low.
        wr_done = 1;
        cycle();
        wr_done = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF;
            cycle();
        end
        wr_en = 0;
`ifdef PINGPONG_OVERRUN_EN
        chk("t6_overrun", overrun, 1'b1);
        chk("t6_overrun_cnt", overrun_cnt, 3);
`endif
        rd_done = 1;
        cycle();
        rd_done = 0;
        cycle();
        rd_addr = 2;
        cycle();
        cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, DEP - 1));
            wr_data = DW'($urandom);
            rd_addr = AW'($urandom_range(0, DEP - 1));
            wr_done = ($urandom_range(0, 19) == 0);
            rd_done = ($urandom_range(0, 14) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
